// File: rtl/period_meter.sv
// Period meter: counts clk cycles between rising edges of event_in,
// optionally averaging 2^AVG_LOG2 periods, with a valid/ready result and timeout.
module period_meter #(
  parameter int WIDTH    = 16,
  parameter int AVG_LOG2 = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic             event_in,
  output logic [WIDTH-1:0] period,
  output logic             valid,
  input  logic             ready,
  output logic             timeout,
  output logic             busy
);

  localparam int CW = WIDTH + AVG_LOG2;
  localparam int NW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
  localparam logic [NW-1:0] LAST_PER = NW'((1 << AVG_LOG2) - 1);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_ARM     = 2'd1;
  localparam logic [1:0] S_MEASURE = 2'd2;
  localparam logic [1:0] S_DONE    = 2'd3;

  logic [1:0]       r_state;
  logic             r_prev;
  logic [CW-1:0]    r_cnt;
  logic [NW-1:0]    r_nper;
  logic [WIDTH-1:0] r_period;
  logic             r_timeout;

  logic             w_edge;
  logic             w_lastPer;
  logic             w_cntFull;

  assign w_edge    = event_in & ~r_prev;
  assign w_lastPer = (r_nper == LAST_PER);
  assign w_cntFull = &r_cnt;

  // The accumulator keeps running across intermediate edges, so on the final
  // edge it holds the sum of all averaged periods; the shift does the divide.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state   <= S_IDLE;
      r_prev    <= 1'b0;
      r_cnt     <= '0;
      r_nper    <= '0;
      r_period  <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_prev <= event_in;
      case (r_state)
        S_IDLE: begin
          if (enable) r_state <= S_ARM;
        end
        S_ARM: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_edge) begin
            r_cnt   <= CW'(1);
            r_nper  <= '0;
            r_state <= S_MEASURE;
          end
        end
        S_MEASURE: begin
          if (!enable) begin
            r_state <= S_IDLE;
          end else if (w_edge) begin
            if (w_lastPer) begin
              r_period  <= r_cnt[CW-1:AVG_LOG2];
              r_timeout <= 1'b0;
              r_state   <= S_DONE;
            end else begin
              r_nper <= r_nper + NW'(1);
              r_cnt  <= r_cnt + CW'(1);
            end
          end else if (w_cntFull) begin
            r_period  <= '1;
            r_timeout <= 1'b1;
            r_state   <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        S_DONE: begin
          if (ready) r_state <= enable ? S_ARM : S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign period  = r_period;
  assign timeout = r_timeout;
  assign valid   = (r_state == S_DONE);
  assign busy    = (r_state == S_ARM) || (r_state == S_MEASURE);

endmodule

// File: tb/tb_period_meter.sv
// Scoreboard bench for period_meter: three instances cover plain, averaged
// and narrow-counter timeout configurations.
module tb_period_meter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic       en8, ev8, rdy8, valid8, timeout8, busy8;
  logic [7:0] period8;
  logic       enA, evA, rdyA, validA, timeoutA, busyA;
  logic [7:0] periodA;
  logic       en4, ev4, rdy4, valid4, timeout4, busy4;
  logic [3:0] period4;

  int vecCount  = 0;
  int missCount = 0;

  logic [8:0] q8[$];
  logic [8:0] qA[$];
  logic [8:0] q4[$];

  period_meter #(.WIDTH(8), .AVG_LOG2(0)) u8 (
    .clk(clk), .rst(rst), .enable(en8), .event_in(ev8), .period(period8),
    .valid(valid8), .ready(rdy8), .timeout(timeout8), .busy(busy8));

  period_meter #(.WIDTH(8), .AVG_LOG2(2)) uAvg (
    .clk(clk), .rst(rst), .enable(enA), .event_in(evA), .period(periodA),
    .valid(validA), .ready(rdyA), .timeout(timeoutA), .busy(busyA));

  period_meter #(.WIDTH(4), .AVG_LOG2(0)) u4 (
    .clk(clk), .rst(rst), .enable(en4), .event_in(ev4), .period(period4),
    .valid(valid4), .ready(rdy4), .timeout(timeout4), .busy(busy4));

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vecCount++;
    if (got !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // One-cycle high pulse on the selected instance, then advance to gap cycles total.
  task automatic applyStimulus(input int dut, input int gap);
    case (dut)
      0: ev8 = 1'b1;
      1: evA = 1'b1;
      default: ev4 = 1'b1;
    endcase
    tick();
    ev8 = 1'b0;
    evA = 1'b0;
    ev4 = 1'b0;
    repeat (gap - 1) tick();
  endtask

  always @(negedge clk) begin
    if (valid8 && rdy8) begin
      if (q8.size() == 0) checkOutput("u8_unexpected", 0, 1);
      else begin
        logic [8:0] e;
        e = q8.pop_front();
        checkOutput("u8_period", 32'(period8), 32'(e[7:0]));
        checkOutput("u8_timeout", 32'(timeout8), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (validA && rdyA) begin
      if (qA.size() == 0) checkOutput("uAvg_unexpected", 0, 1);
      else begin
        logic [8:0] e;
        e = qA.pop_front();
        checkOutput("uAvg_period", 32'(periodA), 32'(e[7:0]));
        checkOutput("uAvg_timeout", 32'(timeoutA), 32'(e[8]));
      end
    end
  end

  always @(negedge clk) begin
    if (valid4 && rdy4) begin
      if (q4.size() == 0) checkOutput("u4_unexpected", 0, 1);
      else begin
        logic [8:0] e;
        e = q4.pop_front();
        checkOutput("u4_period", 32'(period4), 32'(e[7:0]));
        checkOutput("u4_timeout", 32'(timeout4), 32'(e[8]));
      end
    end
  end

  initial begin
    int lat;
    int seen;
    int validCycles;
    rst = 1'b0;
    {en8, ev8, rdy8, enA, evA, rdyA, en4, ev4, rdy4} = '0;
    tick();
    tick();
    @(negedge clk);
    checkOutput("rst_period8", 32'(period8), 0);
    checkOutput("rst_valid8", 32'(valid8), 0);
    checkOutput("rst_timeout8", 32'(timeout8), 0);
    checkOutput("rst_busy8", 32'(busy8), 0);
    checkOutput("rst_periodA", 32'(periodA), 0);
    checkOutput("rst_period4", 32'(period4), 0);
    rst = 1'b1;
    tick();

    // Fixed 10-cycle spacing, re-arming after each handshake, then the minimum period.
    en8 = 1'b1;
    rdy8 = 1'b1;
    tick();
    tick();
    for (int i = 0; i < 3; i++) begin
      q8.push_back({1'b0, 8'd10});
      applyStimulus(0, 10);
      if (i == 0) begin
        @(negedge clk);
        checkOutput("u8_busyMeasure", 32'(busy8), 1);
      end
      applyStimulus(0, 10);
    end
    q8.push_back({1'b0, 8'd2});
    applyStimulus(0, 2);
    applyStimulus(0, 2);
    repeat (4) tick();

    // Averaging over four periods: 40>>2 and 37>>2.
    enA = 1'b1;
    rdyA = 1'b1;
    tick();
    tick();
    applyStimulus(1, 9);
    applyStimulus(1, 10);
    applyStimulus(1, 11);
    applyStimulus(1, 10);
    qA.push_back({1'b0, 8'd10});
    applyStimulus(1, 5);
    applyStimulus(1, 9);
    applyStimulus(1, 9);
    applyStimulus(1, 9);
    applyStimulus(1, 10);
    qA.push_back({1'b0, 8'd9});
    applyStimulus(1, 5);
    enA = 1'b0;

    // Narrow counter: timeout, then an edge landing exactly on the full count.
    en4 = 1'b1;
    rdy4 = 1'b1;
    tick();
    tick();
    q4.push_back({1'b1, 8'd15});
    ev4 = 1'b1;
    tick();
    ev4 = 1'b0;
    lat = 99;
    seen = 0;
    for (int k = 0; k < 40 && seen == 0; k++) begin
      @(negedge clk);
      if (valid4) begin
        seen = 1;
        lat = k;
      end
    end
    checkOutput("u4_timeoutLatency", 32'(lat), 15);
    repeat (5) tick();
    q4.push_back({1'b0, 8'd15});
    applyStimulus(2, 15);
    applyStimulus(2, 5);
    en4 = 1'b0;

    // Backpressure: result held while edges continue and enable drops.
    rdy8 = 1'b0;
    applyStimulus(0, 6);
    applyStimulus(0, 6);
    q8.push_back({1'b0, 8'd6});
    for (int i = 0; i < 5; i++) begin
      ev8 = (i % 2 == 0);
      if (i == 2) en8 = 1'b0;
      @(negedge clk);
      checkOutput("bp_valid", 32'(valid8), 1);
      checkOutput("bp_period", 32'(period8), 6);
      tick();
    end
    ev8 = 1'b0;
    rdy8 = 1'b1;
    @(negedge clk);
    tick();
    @(negedge clk);
    checkOutput("bp_validAfter", 32'(valid8), 0);
    checkOutput("bp_busyAfter", 32'(busy8), 0);

    // Abort three cycles into a measurement, then a clean 7-cycle result.
    en8 = 1'b1;
    tick();
    tick();
    applyStimulus(0, 3);
    en8 = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy8), 0);
    validCycles = 0;
    repeat (6) begin
      @(negedge clk);
      if (valid8) validCycles++;
    end
    checkOutput("abort_noValid", 32'(validCycles), 0);
    en8 = 1'b1;
    tick();
    tick();
    q8.push_back({1'b0, 8'd7});
    applyStimulus(0, 7);
    applyStimulus(0, 7);
    repeat (3) tick();

    // Reset mid-measurement with an edge coincident with reset release.
    applyStimulus(0, 3);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    ev8 = 1'b1;
    @(negedge clk);
    checkOutput("rstM_period", 32'(period8), 0);
    checkOutput("rstM_valid", 32'(valid8), 0);
    checkOutput("rstM_timeout", 32'(timeout8), 0);
    checkOutput("rstM_busy", 32'(busy8), 0);
    tick();
    ev8 = 1'b0;
    tick();
    q8.push_back({1'b0, 8'd4});
    applyStimulus(0, 4);
    applyStimulus(0, 4);
    repeat (3) tick();

    // Reset while a result is pending.
    rdy8 = 1'b0;
    applyStimulus(0, 5);
    applyStimulus(0, 5);
    @(negedge clk);
    checkOutput("rstD_validBefore", 32'(valid8), 1);
    rst = 1'b0;
    tick();
    rst = 1'b1;
    @(negedge clk);
    checkOutput("rstD_period", 32'(period8), 0);
    checkOutput("rstD_valid", 32'(valid8), 0);
    checkOutput("rstD_timeout", 32'(timeout8), 0);
    checkOutput("rstD_busy", 32'(busy8), 0);
    en8 = 1'b0;
    rdy8 = 1'b1;
    repeat (4) tick();

    checkOutput("q8_drained", 32'(q8.size()), 0);
    checkOutput("qA_drained", 32'(qA.size()), 0);
    checkOutput("q4_drained", 32'(q4.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
